// File: rtl/block_checker.sv
// block_checker: streaming begin/end nesting checker, one ASCII character per clock.
// Tracks the current word with a small prefix FSM and keeps a signed, saturating
// nesting depth plus a sticky fail flag. result is high while the stream so far
// is balanced and has never closed an unopened block.
// Optional build macro: BLOCK_CHECKER_CASE_FOLD_EN (case-insensitive keyword match).
module block_checker #(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    output logic       result
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_B,
        S_BE,
        S_BEG,
        S_BEGI,
        S_BEGIN,
        S_E,
        S_EN,
        S_END,
        S_OTHER
    } state_t;

    localparam logic [7:0] CH_NULL  = 8'h00;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_B     = 8'h62;
    localparam logic [7:0] CH_D     = 8'h64;
    localparam logic [7:0] CH_E     = 8'h65;
    localparam logic [7:0] CH_G     = 8'h67;
    localparam logic [7:0] CH_I     = 8'h69;
    localparam logic [7:0] CH_N     = 8'h6e;

    localparam logic signed [CNT_W-1:0] DEPTH_ONE = CNT_W'(1);
    localparam logic signed [CNT_W-1:0] DEPTH_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] DEPTH_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    state_t                   state_q;
    logic signed [CNT_W-1:0]  depth_q;
    logic                     fail_q;

    logic                     is_null;
    logic                     is_space;
    logic [7:0]               ch;
    logic signed [CNT_W-1:0]  depth_inc;
    logic signed [CNT_W-1:0]  depth_dec;

    // Classify the incoming byte and form the letter used for keyword comparison.
    // NOTE: every signal written in an always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        is_null  = (in == CH_NULL);
        is_space = (in == CH_SPACE);
`ifdef BLOCK_CHECKER_CASE_FOLD_EN
        // Forcing bit 5 maps A-Z onto a-z; no non-letter folds onto b/d/e/g/i/n.
        ch = in | 8'h20;
`else
        ch = in;
`endif
    end

    // Saturating +1/-1 of the nesting depth, so long streams never wrap.
    always_comb begin
        depth_inc = depth_q;
        depth_dec = depth_q;
        if (depth_q != DEPTH_MAX) depth_inc = depth_q + DEPTH_ONE;
        if (depth_q != DEPTH_MIN) depth_dec = depth_q - DEPTH_ONE;
    end

    // Word FSM with tentative depth updates and the sticky fail flag.
    // NOTE: sequential state uses non-blocking (<=) assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    // NOTE: all state here is plain flops, so everything is cleared on reset;
    // there is no memory array that would need to be left unreset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            depth_q <= '0;
            fail_q  <= 1'b0;
        end else if (!is_null) begin
            if (is_space) begin
                // A committed 'end' with no open block can never be repaired.
                if (state_q == S_END && depth_q[CNT_W-1]) fail_q <= 1'b1;
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (ch == CH_B)      state_q <= S_B;
                        else if (ch == CH_E) state_q <= S_E;
                        else                 state_q <= S_OTHER;
                    end
                    S_B:    state_q <= (ch == CH_E) ? S_BE   : S_OTHER;
                    S_BE:   state_q <= (ch == CH_G) ? S_BEG  : S_OTHER;
                    S_BEG:  state_q <= (ch == CH_I) ? S_BEGI : S_OTHER;
                    S_BEGI: begin
                        if (ch == CH_N) begin
                            state_q <= S_BEGIN;
                            depth_q <= depth_inc;
                        end else begin
                            state_q <= S_OTHER;
                        end
                    end
                    S_BEGIN: begin
                        // Word continued past 'begin': undo the tentative open.
                        state_q <= S_OTHER;
                        depth_q <= depth_dec;
                    end
                    S_E:    state_q <= (ch == CH_N) ? S_EN : S_OTHER;
                    S_EN: begin
                        if (ch == CH_D) begin
                            state_q <= S_END;
                            depth_q <= depth_dec;
                        end else begin
                            state_q <= S_OTHER;
                        end
                    end
                    S_END: begin
                        // Word continued past 'end': undo the tentative close.
                        state_q <= S_OTHER;
                        depth_q <= depth_inc;
                    end
                    default: state_q <= S_OTHER;
                endcase
            end
        end
    end

    // Status is combinational from registered state so tentative counts show at once.
    always_comb begin
        result = !fail_q && (depth_q == '0);
    end

endmodule

// File: tb/tb_block_checker.sv
// Directed bench for block_checker. Each driven character pushes its expected
// result onto a scoreboard queue; the entry is popped and compared just after
// the rising edge that samples the character. DUT uses a 4-bit depth counter so
// saturation can be reached in a short run.
module tb_block_checker;

    typedef struct {
        string tag;
        logic  exp;
    } sb_t;

    logic       clk;
    logic       reset;
    logic [7:0] in_c;
    logic       result;

    sb_t sb_q[$];
    int  vectors;
    int  miscompares;

    block_checker #(.CNT_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in_c),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run must end on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic compare_front();
        sb_t e;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard: queue empty, observed result=%b expected an entry", result);
        end else begin
            e = sb_q.pop_front();
            assert (result === e.exp) else begin
                miscompares++;
                $error("FAIL %s: result observed=%b expected=%b", e.tag, result, e.exp);
            end
        end
    endtask

    task automatic push_exp(input string tag, input logic exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Drive one character away from the sampling edge, check after the edge.
    task automatic drive(input logic [7:0] c, input logic exp, input string tag);
        @(negedge clk);
        in_c = c;
        push_exp(tag, exp);
        @(posedge clk);
        #1;
        compare_front();
    endtask

    // exp is a string of '0'/'1', one expected result per character of s.
    task automatic send_str(input string s, input string exp, input string tag);
        for (int i = 0; i < s.len(); i++) begin
            drive(s[i], exp[i] == "1", $sformatf("%s[%0d]'%s'", tag, i, s.substr(i, i)));
        end
    endtask

    // Asynchronous reset pulse; result must be 1 while reset is held low.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        #1;
        push_exp(tag, 1'b1);
        compare_front();
        @(negedge clk);
        reset = 1'b1;
        in_c  = 8'h00;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        in_c        = 8'h00;
        #12;
        push_exp("reset_state", 1'b1);
        compare_front();
        @(negedge clk);
        reset = 1'b1;

        // Non-keyword word, then 'begina' reverts the tentative open.
        send_str("hi begina", "111111101", "t1");

        // Balanced pair, with idle (null) characters holding state mid-word.
        pulse_reset("t2_reset");
        send_str("be", "11", "t2a");
        drive(8'h00, 1'b1, "t2_null_midword");
        send_str("gin", "110", "t2b");
        drive(8'h00, 1'b0, "t2_null_open");
        send_str(" end ", "00011", "t2c");

        // Close before open: fail is sticky until reset.
        pulse_reset("t3_reset_pre");
        send_str("end begin end ", "11000000000000", "t3");
        pulse_reset("t3_reset_clears_fail");

        // Nested blocks; 'endx' reverts the tentative close.
        send_str("begin begin end endx ", "111100000000000000100", "t4");

        // Upper/mixed-case keywords.
        pulse_reset("t5_reset");
`ifdef BLOCK_CHECKER_CASE_FOLD_EN
        send_str("BeGiN EnD", "111100001", "t5_fold");
`else
        send_str("BeGiN EnD", "111111111", "t5_nofold");
`endif

        // Asynchronous reset mid-'begi' discards the partial word.
        pulse_reset("t6_reset_pre");
        send_str("begi", "1111", "t6a");
        #2;
        reset = 1'b0;
        #1;
        push_exp("t6_async_reset", 1'b1);
        compare_front();
        @(negedge clk);
        reset = 1'b1;
        send_str("n begin", "1111110", "t6b");

        // Saturation of the 4-bit depth at +7: eight opens, seven closes balance.
        pulse_reset("t7_reset");
        for (int i = 0; i < 8; i++) begin
            send_str("begin ", (i == 0) ? "111100" : "000000", $sformatf("t7_open%0d", i));
        end
        for (int i = 0; i < 7; i++) begin
            send_str("end ", (i == 6) ? "0011" : "0000", $sformatf("t7_close%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
